// File: rtl/cache_mem_arbiter.sv
// Arbitrates one word-wide memory port between the I-cache and D-cache:
// 4-word block refills assembled into 128 bits, plus D-side write-throughs.
module cache_mem_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_readmiss,
  input  logic [31:0]  i_addr,
  output logic         i_readready,
  output logic [127:0] i_block,
  input  logic         d_readmiss,
  input  logic         d_writethru,
  input  logic [31:0]  d_addr,
  input  logic [31:0]  d_wdata,
  output logic         d_readready,
  output logic         d_writeready,
  output logic [127:0] d_block,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ack,
  output logic         gnt_d,
  output logic         gnt_i
);

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t       state, state_nx;
  logic [1:0]   cnt;
  logic [31:2]  addr_q;
  logic [31:0]  wdata_q;
  logic         side_d;     // 1 = current owner is the D-side
  logic         rd_q;       // a refill follows (or is) the access
  logic         rr_d_next;  // round-robin pointer, 0 = I-next
  logic [95:0]  buf_q;      // words 0..2; word 3 goes straight to the block
  logic         d_pend, i_pend, pick_d;
  logic         unused_addr_bits;

  assign d_pend = d_readmiss | d_writethru;
  assign i_pend = i_readmiss;
  assign pick_d = d_pend & (~i_pend | (ARB_MODE == 0) | rr_d_next);
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  assign gnt_d = (state != IDLE) &  side_d;
  assign gnt_i = (state != IDLE) & ~side_d;

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      IDLE: if (d_pend | i_pend) state_nx = (pick_d & d_writethru) ? WR : RD;
      WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q, 2'b00};
        mem_wdata = wdata_q;
        if (mem_ack) state_nx = rd_q ? RD : RESP;
      end
      RD: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:4], cnt, 2'b00};
        if (mem_ack && cnt == 2'd3) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      side_d       <= 1'b0;
      rd_q         <= 1'b0;
      rr_d_next    <= 1'b0;
      buf_q        <= '0;
      i_block      <= 128'h0;
      d_block      <= 128'h0;
      i_readready  <= 1'b0;
      d_readready  <= 1'b0;
      d_writeready <= 1'b0;
    end else begin
      state        <= state_nx;
      i_readready  <= 1'b0;
      d_readready  <= 1'b0;
      d_writeready <= 1'b0;
      case (state)
        IDLE: if (d_pend | i_pend) begin
          side_d    <= pick_d;
          addr_q    <= pick_d ? d_addr[31:2] : i_addr[31:2];
          wdata_q   <= d_wdata;
          rd_q      <= pick_d ? d_readmiss : 1'b1;
          cnt       <= 2'd0;
          rr_d_next <= ~pick_d;
        end
        WR: if (mem_ack) d_writeready <= 1'b1;
        RD: if (mem_ack) begin
          cnt <= cnt + 2'd1;
          case (cnt)
            2'd0: buf_q[31:0]  <= mem_rdata;
            2'd1: buf_q[63:32] <= mem_rdata;
            2'd2: buf_q[95:64] <= mem_rdata;
            default: begin
              // Blocks update only on completion so they stay stable between refills
              if (side_d) begin
                d_block     <= {mem_rdata, buf_q};
                d_readready <= 1'b1;
              end else begin
                i_block     <= {mem_rdata, buf_q};
                i_readready <= 1'b1;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench: fixed-priority instance with a stallable memory model,
// plus a round-robin instance for the alternation check.
module tb_cache_mem_arbiter;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  // fixed-priority instance
  logic         i_readmiss, d_readmiss, d_writethru;
  logic [31:0]  i_addr, d_addr, d_wdata;
  logic         i_readready, d_readready, d_writeready;
  logic [127:0] i_block, d_block;
  logic         mem_req, mem_we, gnt_d, gnt_i;
  logic [31:0]  mem_addr, mem_wdata;
  logic [31:0]  mem_rdata = 32'h0;
  logic         mem_ack   = 1'b0;

  // round-robin instance
  logic         i_readmiss1, d_readmiss1;
  logic [31:0]  i_addr1, d_addr1;
  logic         d_writethru1;
  logic [31:0]  d_wdata1;
  logic         i_readready1, d_readready1, d_writeready1;
  logic [127:0] i_block1, d_block1;
  logic         mem_req1, mem_we1, gnt_d1, gnt_i1;
  logic [31:0]  mem_addr1, mem_wdata1;
  logic [31:0]  mem_rdata1 = 32'h0;
  logic         mem_ack1   = 1'b0;

  cache_mem_arbiter #(.ARB_MODE(0)) dut0 (
    .Clk(Clk), .Rst(Rst),
    .i_readmiss(i_readmiss), .i_addr(i_addr), .i_readready(i_readready), .i_block(i_block),
    .d_readmiss(d_readmiss), .d_writethru(d_writethru), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_readready(d_readready), .d_writeready(d_writeready), .d_block(d_block),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .gnt_d(gnt_d), .gnt_i(gnt_i));

  cache_mem_arbiter #(.ARB_MODE(1)) dut1 (
    .Clk(Clk), .Rst(Rst),
    .i_readmiss(i_readmiss1), .i_addr(i_addr1), .i_readready(i_readready1), .i_block(i_block1),
    .d_readmiss(d_readmiss1), .d_writethru(d_writethru1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_readready(d_readready1), .d_writeready(d_writeready1), .d_block(d_block1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .mem_ack(mem_ack1), .gnt_d(gnt_d1), .gnt_i(gnt_i1));

  int nvec = 0;
  int nerr = 0;

  // memory model: unwritten words read back as addr ^ 5A5A_0000
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rlog[$];
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];
  bit          stall_en = 0;
  int          wcnt = 0, stall_seen = 0, hold_err = 0;
  logic [31:0] wait_addr = 32'h0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  always @(negedge Clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (mem_req) begin
      if (wcnt == 0) wait_addr = mem_addr;
      else if (mem_addr !== wait_addr) hold_err++;
      if (wcnt >= ((stall_en && !mem_we && mem_addr[3:2] == 2'd2) ? 5 : 0)) begin
        if (wcnt > 0) stall_seen = wcnt;
        wcnt    = 0;
        mem_ack = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wlog_a.push_back(mem_addr);
          wlog_d.push_back(mem_wdata);
        end else begin
          mem_rdata = rd_word(mem_addr);
          rlog.push_back(mem_addr);
        end
      end else wcnt++;
    end else begin
      if (wcnt != 0) hold_err++;
      wcnt = 0;
    end
  end

  always @(negedge Clk) begin
    if (mem_ack1) mem_ack1 = 1'b0;
    else if (mem_req1) begin
      mem_ack1   = 1'b1;
      mem_rdata1 = mem_addr1 ^ 32'h5A5A_0000;
    end
  end

  // pulse monitor
  int cyc = 0, ir_cnt = 0, dr_cnt = 0, dw_cnt = 0, dw_cyc = 0, dr_cyc = 0, inv_err = 0;
  bit ord0[$];  // 1 = D
  bit ord1[$];
  always @(negedge Clk) begin
    cyc++;
    if (i_readready) begin ir_cnt++; ord0.push_back(1'b0); end
    if (d_readready) begin dr_cnt++; dr_cyc = cyc; ord0.push_back(1'b1); end
    if (d_writeready) begin dw_cnt++; dw_cyc = cyc; end
    if (i_readready1) ord1.push_back(1'b0);
    if (d_readready1) ord1.push_back(1'b1);
    if ((gnt_i && gnt_d) || (gnt_i1 && gnt_d1) ||
        (i_readready && (d_readready || d_writeready)) ||
        (i_readready1 && (d_readready1 || d_writeready1))) inv_err++;
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    i_readmiss = 0; d_readmiss = 0; d_writethru = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    i_readmiss1 = 0; d_readmiss1 = 0; d_writethru1 = 0;
    i_addr1 = 32'h1000; d_addr1 = 32'h2000; d_wdata1 = 0;
    step(3);
    Rst = 1'b0;
    step(2);
    nvec++;
    if ({mem_req, mem_we, gnt_d, gnt_i, i_readready, d_readready, d_writeready} !== 7'b0) begin
      nerr++; $display("FAIL reset_ctrl: got %b expected 0", {mem_req, mem_we, gnt_d, gnt_i, i_readready, d_readready, d_writeready});
    end
    nvec++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      nerr++; $display("FAIL reset_bus: got %h expected 0", {mem_addr, mem_wdata});
    end
    nvec++;
    if ({i_block, d_block, i_block1, d_block1} !== 512'h0) begin
      nerr++; $display("FAIL reset_blocks: got nonzero block expected 0");
    end
  endtask

  task automatic test_i_refill;
    int c0 = ir_cnt;
    rlog.delete();
    i_addr = 32'h0000_1234; i_readmiss = 1'b1;
    for (int k = 0; k < 100 && ir_cnt == c0; k++) step(1);
    i_readmiss = 1'b0;
    step(4);
    nvec++;
    if (ir_cnt !== c0 + 1) begin nerr++; $display("FAIL i_refill_pulse: got %0d expected %0d", ir_cnt - c0, 1); end
    nvec++;
    if (rlog.size() != 4 || rlog[0] !== 32'h1230 || rlog[1] !== 32'h1234 || rlog[2] !== 32'h1238 || rlog[3] !== 32'h123C) begin
      nerr++; $display("FAIL i_refill_addrs: got %p expected 1230,1234,1238,123c", rlog);
    end
    nvec++;
    if (i_block !== 128'h5A5A123C_5A5A1238_5A5A1234_5A5A1230) begin
      nerr++; $display("FAIL i_refill_block: got %h expected 5a5a123c5a5a12385a5a12345a5a1230", i_block);
    end
    nvec++;
    if ({mem_req, gnt_i} !== 2'b00) begin nerr++; $display("FAIL i_refill_idle: got %b expected 00", {mem_req, gnt_i}); end
  endtask

  task automatic test_d_write_hit;
    int cw = dw_cnt, cr = dr_cnt;
    rlog.delete(); wlog_a.delete(); wlog_d.delete();
    d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_writethru = 1'b1;
    for (int k = 0; k < 100 && dw_cnt == cw; k++) step(1);
    d_writethru = 1'b0;
    step(4);
    nvec++;
    if (dw_cnt !== cw + 1) begin nerr++; $display("FAIL wr_hit_pulse: got %0d expected 1", dw_cnt - cw); end
    nvec++;
    if (wlog_a.size() != 1 || wlog_a[0] !== 32'h40 || wlog_d[0] !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL wr_hit_write: got %p/%p expected 40/deadbeef", wlog_a, wlog_d);
    end
    nvec++;
    if (dr_cnt !== cr || rlog.size() != 0) begin
      nerr++; $display("FAIL wr_hit_noread: got %0d pulses %0d reads expected 0 0", dr_cnt - cr, rlog.size());
    end
    nvec++;
    if (mem_req !== 1'b0) begin nerr++; $display("FAIL wr_hit_req: got %b expected 0", mem_req); end
  endtask

  task automatic test_d_write_miss;
    int cw = dw_cnt, cr = dr_cnt;
    rlog.delete(); wlog_a.delete(); wlog_d.delete();
    d_addr = 32'h84; d_wdata = 32'h1234_5678; d_writethru = 1'b1; d_readmiss = 1'b1;
    for (int k = 0; k < 100 && dr_cnt == cr; k++) step(1);
    d_writethru = 1'b0; d_readmiss = 1'b0;
    step(4);
    nvec++;
    if (dw_cnt !== cw + 1 || dr_cnt !== cr + 1 || !(dw_cyc < dr_cyc)) begin
      nerr++; $display("FAIL wr_miss_order: got wr=%0d rd=%0d wc=%0d rc=%0d expected 1 1 wc<rc", dw_cnt - cw, dr_cnt - cr, dw_cyc, dr_cyc);
    end
    nvec++;
    if (wlog_a.size() != 1 || wlog_a[0] !== 32'h84 || rlog.size() != 4 || rlog[0] !== 32'h80 || rlog[3] !== 32'h8C) begin
      nerr++; $display("FAIL wr_miss_seq: got w=%p r=%p expected w=84 r=80..8c", wlog_a, rlog);
    end
    nvec++;
    if (d_block !== 128'h5A5A008C_5A5A0088_12345678_5A5A0080) begin
      nerr++; $display("FAIL wr_miss_block: got %h expected 5a5a008c5a5a0088123456785a5a0080", d_block);
    end
  endtask

  task automatic test_conflict_fixed;
    int ci = ir_cnt, cd = dr_cnt;
    rlog.delete(); ord0.delete();
    i_addr = 32'h200; d_addr = 32'h300;
    i_readmiss = 1'b1; d_readmiss = 1'b1;
    for (int k = 0; k < 100 && dr_cnt == cd; k++) step(1);
    d_readmiss = 1'b0;
    for (int k = 0; k < 100 && ir_cnt == ci; k++) step(1);
    i_readmiss = 1'b0;
    step(3);
    nvec++;
    if (ord0.size() != 2 || ord0[0] !== 1'b1 || ord0[1] !== 1'b0) begin
      nerr++; $display("FAIL conflict_order: got %p expected D then I (1,0)", ord0);
    end
    nvec++;
    if (rlog.size() != 8 || rlog[0] !== 32'h300 || rlog[3] !== 32'h30C || rlog[4] !== 32'h200) begin
      nerr++; $display("FAIL conflict_addrs: got %p expected 300..30c,200..20c", rlog);
    end
    nvec++;
    if (d_block !== 128'h5A5A030C_5A5A0308_5A5A0304_5A5A0300 || i_block !== 128'h5A5A020C_5A5A0208_5A5A0204_5A5A0200) begin
      nerr++; $display("FAIL conflict_blocks: got d=%h i=%h expected words 5a5a03xx / 5a5a02xx", d_block, i_block);
    end
  endtask

  task automatic test_stall;
    int cd = dr_cnt;
    rlog.delete(); stall_seen = 0; hold_err = 0; stall_en = 1;
    d_addr = 32'h500; d_readmiss = 1'b1;
    for (int k = 0; k < 100 && dr_cnt == cd; k++) step(1);
    d_readmiss = 1'b0;
    stall_en = 0;
    step(3);
    nvec++;
    if (stall_seen !== 5 || hold_err !== 0) begin
      nerr++; $display("FAIL stall_hold: got wait=%0d hold_err=%0d expected 5 0", stall_seen, hold_err);
    end
    nvec++;
    if (rlog.size() != 4 || rlog[2] !== 32'h508) begin
      nerr++; $display("FAIL stall_addrs: got %p expected 500..50c", rlog);
    end
    nvec++;
    if (d_block !== 128'h5A5A050C_5A5A0508_5A5A0504_5A5A0500) begin
      nerr++; $display("FAIL stall_block: got %h expected 5a5a050c5a5a05085a5a05045a5a0500", d_block);
    end
  endtask

  task automatic test_reset_mid;
    int ci = ir_cnt;
    int k;
    i_addr = 32'h600; i_readmiss = 1'b1;
    for (k = 0; k < 100 && !(mem_req && mem_addr == 32'h608); k++) step(1);
    nvec++;
    if (k >= 100) begin nerr++; $display("FAIL rst_mid_reach: got timeout expected word2 issue"); end
    Rst = 1'b1;
    #1;
    nvec++;
    if ({mem_req, gnt_i, gnt_d, i_readready, mem_addr} !== 36'h0) begin
      nerr++; $display("FAIL rst_mid_async: got %h expected 0", {mem_req, gnt_i, gnt_d, i_readready, mem_addr});
    end
    nvec++;
    if (i_block !== 128'h0) begin nerr++; $display("FAIL rst_mid_block: got %h expected 0", i_block); end
    i_readmiss = 1'b0;
    step(2);
    Rst = 1'b0;
    step(5);
    nvec++;
    if (ir_cnt !== ci) begin nerr++; $display("FAIL rst_mid_nopulse: got %0d pulses expected 0", ir_cnt - ci); end
    rlog.delete();
    i_readmiss = 1'b1;
    for (k = 0; k < 100 && ir_cnt == ci; k++) step(1);
    i_readmiss = 1'b0;
    step(3);
    nvec++;
    if (rlog.size() != 4 || rlog[0] !== 32'h600 || i_block !== 128'h5A5A060C_5A5A0608_5A5A0604_5A5A0600) begin
      nerr++; $display("FAIL rst_mid_restart: got %p block %h expected 600..60c", rlog, i_block);
    end
  endtask

  task automatic test_round_robin;
    ord1.delete();
    i_readmiss1 = 1'b1; d_readmiss1 = 1'b1;
    for (int k = 0; k < 200 && ord1.size() < 4; k++) step(1);
    i_readmiss1 = 1'b0; d_readmiss1 = 1'b0;
    step(3);
    nvec++;
    if (ord1.size() != 4 || ord1[0] !== 1'b0 || ord1[1] !== 1'b1 || ord1[2] !== 1'b0 || ord1[3] !== 1'b1) begin
      nerr++; $display("FAIL rr_order: got %p expected I,D,I,D (0,1,0,1)", ord1);
    end
    nvec++;
    if (i_block1 !== 128'h5A5A100C_5A5A1008_5A5A1004_5A5A1000 || d_block1 !== 128'h5A5A200C_5A5A2008_5A5A2004_5A5A2000) begin
      nerr++; $display("FAIL rr_blocks: got i=%h d=%h", i_block1, d_block1);
    end
  endtask

  task automatic test_invariants;
    nvec++;
    if (inv_err !== 0) begin nerr++; $display("FAIL invariants: got %0d violations expected 0", inv_err); end
  endtask

  initial begin
    test_reset();
    test_i_refill();
    test_d_write_hit();
    test_d_write_miss();
    test_conflict_fixed();
    test_stall();
    test_reset_mid();
    test_round_robin();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one word-wide main-memory port between the instruction cache and the data cache. Both caches are 2-way, 4-word-block, write-through.
- Sequences block refills as 4 single-word reads and returns them as one 128-bit block. Also issues data-side write-throughs.
- Signals completion back to each cache with ready pulses. Sits between both caches and the memory model in the pipelined processor.

Parameters:
- ARB_MODE, 0, arbitration policy. 0 = fixed priority, D-side wins. 1 = round-robin between I and D, alternating on conflict.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset
- i_readmiss  in  1  I-cache block read request, level
- i_addr  in  32  I-cache miss address
- i_readready  out  1  1-cycle pulse: i_block valid
- i_block  out  128  refilled I block
- d_readmiss  in  1  D-cache block read request, level
- d_writethru  in  1  D-cache word write request, level
- d_addr  in  32  D-cache address
- d_wdata  in  32  D write data
- d_readready  out  1  1-cycle pulse: d_block valid
- d_writeready  out  1  1-cycle pulse: write-through completed
- d_block  out  128  refilled D block
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  1-cycle pulse: current access done
- gnt_d  out  1  D-side owns memory (debug)
- gnt_i  out  1  I-side owns memory (debug)

Behaviour:
- Reset: Rst is asynchronous, active-high; clock is Clk. All outputs reset to 0, blocks to 128'h0. State = IDLE, word counter = 0, round-robin pointer = I-next.
- Reset mid-transaction: the access is abandoned and mem_req drops immediately. No ready pulse is issued afterwards.
- States: IDLE, WR, RD, RESP.
- IDLE: sample requests.
  - D pending = d_readmiss | d_writethru. I pending = i_readmiss.
  - Grant D if only D pending. Grant I if only I pending.
  - If both pending: ARB_MODE=0 grants D. ARB_MODE=1 grants the side opposite the last grant.
  - On grant: latch the address, d_wdata and the request type. Set gnt_x.
  - Go to WR if D-side with d_writethru=1, else RD.
- WR:
  - mem_req=1, mem_we=1, mem_addr={addr[31:2],2'b00}, mem_wdata=latched data.
  - On mem_ack: pulse d_writeready next cycle. If latched d_readmiss=1 (write miss), go to RD with counter=0; else go to RESP.
  - Write-before-read order is mandatory, so the refill returns post-write data.
- RD:
  - mem_req=1, mem_we=0, mem_addr={addr[31:4],cnt[1:0],2'b00}.
  - On mem_ack: capture mem_rdata into block bits [32*cnt+31 : 32*cnt], then cnt++.
  - Back-to-back: the request for word cnt+1 is presented in the cycle after the ack.
  - After the ack for cnt=3, go to RESP.
  - mem_req may stay high across words; mem_addr changes only after an ack.
- RESP (1 cycle):
  - Pulse i_readready or d_readready per grant. The block output stays stable until the next refill for that side.
  - For a write hit (WR only): d_writeready pulses in this cycle and there is no read pulse.
  - Clear gnt_x. Return to IDLE.
  - Requests are ignored in RESP; the requester must drop its request on the edge where ready is high.
- Requests changing while granted are ignored; only latched values are used.
- The non-granted side waits with its request held. No request is lost.
- mem_ack while mem_req=0 is ignored.
- Latency with 1-cycle memory ack:
  - read refill = 1 (grant) + 4×(issue+ack) + 1 (RESP).
  - write-through = grant + 2 + RESP.
- Invariants: only one of gnt_i/gnt_d is high at a time. Ready pulses are never coincident across sides.

Test Plan:
- I refill: i_readmiss=1, i_addr=32'h0000_1234, memory returns words A0..A3 for addresses 0x1230,0x1234,0x1238,0x123C → mem_addr sequence 0x1230,0x1234,0x1238,0x123C; i_block={A3,A2,A1,A0}; single i_readready pulse.
- D write hit: d_writethru=1, d_addr=0x40, d_wdata=0xDEADBEEF → one mem write to 0x40 with 0xDEADBEEF; one d_writeready pulse; no d_readready; mem_req low afterwards.
- D write miss: d_writethru=d_readmiss=1, addr 0x84 → write to 0x84 first, then reads 0x80..0x8C; d_writeready pulse, then d_readready pulse; d_block word1 = written value.
- Conflict: i_readmiss and d_readmiss rise in the same cycle. ARB_MODE=0 → D served fully, then I. ARB_MODE=1 → alternation over 4 consecutive conflicts: I, D, I, D starting from reset pointer.
- Memory stall: mem_ack delayed 5 cycles on word 2 → mem_addr held on word 2's address with mem_req=1 throughout; final block correct.
- Reset during RD at cnt=2 → all outputs 0 asynchronously; no ready pulse; next request starts at word 0.
